// File: rtl/pxconv_window_loader.sv
// pxconv_window_loader
// RGB565 to 8-bit grey window loader. PX_PER_BEAT pixels arrive per AXI beat;
// each lane is converted and written to its own BRAM bank at a shared word
// address. The banks form a circular WND_ROWS-line window. Read requests are
// credit-based: bursts are advertised only when the window has room for them.
//
// Build option: define PXCONV_LUMA_WEIGHTS_EN to use weighted luma
// (77R + 150G + 29B) >> 8 instead of the plain (R + G + B) / 3 average.
//
// Pipeline: S1 captures the beat, S2 converts and registers the bank write.
module pxconv_window_loader #(
   parameter int PX_PER_BEAT  = 2,
   parameter int IMG_W        = 640,
   parameter int IMG_H        = 480,
   parameter int WND_ROWS     = 7,
   parameter int PRIME_BURST  = 128,
   parameter int STEADY_BURST = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [16*PX_PER_BEAT-1:0] axi_to_pxconv_data,
   input  logic                      axi_to_pxconv_valid,
   input  logic                      axi_rd_start,
   input  logic                      pixel_ack,
   output logic                      pxconv_to_axi_ready_to_rd,
   output logic [11:0]               pxconv_to_axi_mst_length,
   output logic [4*PX_PER_BEAT-1:0]  pxconv_to_bram_we,
   output logic [PX_PER_BEAT-1:0]    pxconv_to_bram_wr_en,
   output logic [32*PX_PER_BEAT-1:0] pxconv_to_bram_data,
   output logic [31:0]               pxconv_to_bram_addr,
   output logic                      wnd_in_bram,
   output logic                      frame_done,
   output logic [2:0]                err_flags
);

   localparam int WND_DEPTH   = WND_ROWS * IMG_W / PX_PER_BEAT;
   localparam int FRAME_BEATS = IMG_W * IMG_H / PX_PER_BEAT;
   localparam int CW          = $clog2(FRAME_BEATS + WND_DEPTH + 1) + 1;

   typedef logic [CW-1:0]        cnt_t;
   typedef logic signed [CW:0]   fill_t;

   localparam cnt_t  C_WND    = cnt_t'(WND_DEPTH);
   localparam cnt_t  C_FRAME  = cnt_t'(FRAME_BEATS);
   localparam cnt_t  C_PRIME  = cnt_t'(PRIME_BURST);
   localparam cnt_t  C_STEADY = cnt_t'(STEADY_BURST);
   localparam fill_t C_WND_F  = fill_t'(WND_DEPTH);

   // stage registers
   logic [16*PX_PER_BEAT-1:0] r_s1_data;
   logic                      r_s1_valid;
   logic [PX_PER_BEAT-1:0]    r_wr_en;
   logic [32*PX_PER_BEAT-1:0] r_data;
   logic [31:0]               r_addr;
   logic                      r_frame_done;
   cnt_t                      r_wr_ptr;
   cnt_t                      r_frame_cnt;

   // credit / flow registers
   cnt_t                      r_out;
   cnt_t                      r_res;
   cnt_t                      r_req;
   logic [11:0]               r_len;
   logic                      r_ready;
   fill_t                     r_fill;
   logic                      r_wnd;
   logic [2:0]                r_err;

   // combinational next values
   logic                      w_rd_acc;
   logic                      w_beat_acc;
   logic                      w_ack_acc;
   cnt_t                      w_len;
   cnt_t                      w_out_nxt;
   cnt_t                      w_res_nxt;
   cnt_t                      w_req_sum;
   cnt_t                      w_req_nxt;
   cnt_t                      w_len_nxt;
   logic                      w_ready_nxt;
   fill_t                     w_fill_nxt;
   logic [32*PX_PER_BEAT-1:0] w_grey_data;

   function automatic logic [7:0] f_grey(input logic [15:0] p);
      logic [7:0]  r8;
      logic [7:0]  g8;
      logic [7:0]  b8;
`ifdef PXCONV_LUMA_WEIGHTS_EN
      logic [15:0] sum;
`else
      logic [9:0]  sum;
`endif
      r8 = {p[15:11], 3'b000};
      g8 = {p[10:5],  2'b00};
      b8 = {p[4:0],   3'b000};
`ifdef PXCONV_LUMA_WEIGHTS_EN
      // max 77*248 + 150*252 + 29*248 = 64088, fits in 16 bits
      sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
      return sum[15:8];
`else
      // max 748 / 3 = 249, fits in 8 bits
      sum = {2'b00, r8} + {2'b00, g8} + {2'b00, b8};
      sum = sum / 10'd3;
      return sum[7:0];
`endif
   endfunction

   // Credit bookkeeping: accepted events and the post-update counter values
   always_comb begin
      w_rd_acc    = axi_rd_start & r_ready;
      w_beat_acc  = axi_to_pxconv_valid & (r_out != '0);
      w_ack_acc   = pixel_ack & (r_res != '0);
      w_len       = cnt_t'(r_len);
      w_out_nxt   = r_out + (w_rd_acc ? w_len : '0) - (w_beat_acc ? cnt_t'(1) : '0);
      w_res_nxt   = r_res + (w_rd_acc ? w_len : '0) - (w_ack_acc ? cnt_t'(1) : '0);
      w_req_sum   = r_req + (w_rd_acc ? w_len : '0);
      w_req_nxt   = (w_req_sum >= C_FRAME) ? (w_req_sum - C_FRAME) : w_req_sum;
      w_len_nxt   = (w_req_nxt < C_WND) ? C_PRIME : C_STEADY;
      w_ready_nxt = ((C_WND - w_res_nxt) >= w_len_nxt) && (w_req_nxt < C_FRAME);
      w_fill_nxt  = r_fill + (r_s1_valid ? fill_t'(1) : fill_t'(0))
                           - (w_ack_acc ? fill_t'(1) : fill_t'(0));
   end

   // Per-lane grey conversion on the S1 beat
   always_comb begin
      w_grey_data = '0;
      for (int k = 0; k < PX_PER_BEAT; k++) begin
         w_grey_data[32*k +: 32] = {24'd0, f_grey(r_s1_data[16*k +: 16])};
      end
   end

   // S1: capture accepted beats; unsolicited beats never enter the pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_data  <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_beat_acc;
         if (w_beat_acc) begin
            r_s1_data <= axi_to_pxconv_data;
         end
      end
   end

   // S2: bank write, window address and frame position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en      <= '0;
         r_data       <= '0;
         r_addr       <= '0;
         r_frame_done <= 1'b0;
         r_wr_ptr     <= '0;
         r_frame_cnt  <= '0;
      end else begin
         r_wr_en      <= {PX_PER_BEAT{r_s1_valid}};
         r_frame_done <= 1'b0;
         if (r_s1_valid) begin
            r_data <= w_grey_data;
            r_addr <= 32'(r_wr_ptr);
            if (r_frame_cnt == C_FRAME - cnt_t'(1)) begin
               // a new frame restarts the window at word 0
               r_frame_cnt  <= '0;
               r_wr_ptr     <= '0;
               r_frame_done <= 1'b1;
            end else begin
               r_frame_cnt <= r_frame_cnt + cnt_t'(1);
               r_wr_ptr    <= (r_wr_ptr == C_WND - cnt_t'(1)) ? '0 : r_wr_ptr + cnt_t'(1);
            end
         end
      end
   end

   // Credit counters, advertised burst and window occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_res   <= '0;
         r_req   <= '0;
         r_len   <= 12'(PRIME_BURST);
         r_ready <= 1'b0;
         r_fill  <= '0;
         r_wnd   <= 1'b0;
      end else begin
         r_out   <= w_out_nxt;
         r_res   <= w_res_nxt;
         r_req   <= w_req_nxt;
         r_len   <= 12'(w_len_nxt);
         r_ready <= w_ready_nxt;
         r_fill  <= w_fill_nxt;
         r_wnd   <= (w_fill_nxt >= C_WND_F);
      end
   end

   // Sticky protocol error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= '0;
      end else begin
         if (axi_to_pxconv_valid && (r_out == '0)) r_err[0] <= 1'b1;
         if (pixel_ack && (r_res == '0))           r_err[1] <= 1'b1;
         if (axi_rd_start && !r_ready)             r_err[2] <= 1'b1;
      end
   end

   assign pxconv_to_axi_ready_to_rd = r_ready;
   assign pxconv_to_axi_mst_length  = r_len;
   assign pxconv_to_bram_we         = '1;
   assign pxconv_to_bram_wr_en      = r_wr_en;
   assign pxconv_to_bram_data       = r_data;
   assign pxconv_to_bram_addr       = r_addr;
   assign wnd_in_bram               = r_wnd;
   assign frame_done                = r_frame_done;
   assign err_flags                 = r_err;

endmodule

// File: tb/tb_pxconv_window_loader.sv
// tb_pxconv_window_loader
// Random-stimulus bench for pxconv_window_loader with a transaction-level
// reference model (counters, a queue of expected bank writes). Uses a reduced
// image so a full frame streams quickly: 160-beat window, 1024-beat frame.
`timescale 1ns/1ps
module tb_pxconv_window_loader;

   localparam int PX       = 2;
   localparam int IMG_W    = 64;
   localparam int IMG_H    = 32;
   localparam int WND_ROWS = 5;
   localparam int PRIME    = 32;
   localparam int STEADY   = 8;
   localparam int WND      = WND_ROWS * IMG_W / PX;
   localparam int FRAME    = IMG_W * IMG_H / PX;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [16*PX-1:0]  data = '0;
   logic              valid = 1'b0;
   logic              rd_start = 1'b0;
   logic              ack = 1'b0;
   logic              ready;
   logic [11:0]       len;
   logic [4*PX-1:0]   bram_we;
   logic [PX-1:0]     wr_en;
   logic [32*PX-1:0]  bram_data;
   logic [31:0]       bram_addr;
   logic              wnd;
   logic              fdone;
   logic [2:0]        err;

   pxconv_window_loader #(
      .PX_PER_BEAT (PX),
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .WND_ROWS    (WND_ROWS),
      .PRIME_BURST (PRIME),
      .STEADY_BURST(STEADY)
   ) u_dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .axi_to_pxconv_data       (data),
      .axi_to_pxconv_valid      (valid),
      .axi_rd_start             (rd_start),
      .pixel_ack                (ack),
      .pxconv_to_axi_ready_to_rd(ready),
      .pxconv_to_axi_mst_length (len),
      .pxconv_to_bram_we        (bram_we),
      .pxconv_to_bram_wr_en     (wr_en),
      .pxconv_to_bram_data      (bram_data),
      .pxconv_to_bram_addr      (bram_addr),
      .wnd_in_bram              (wnd),
      .frame_done               (fdone),
      .err_flags                (err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // reference model state
   typedef struct {
      int          due;
      logic [63:0] d;
      int          addr;
      bit          last;
   } wr_t;

   wr_t      q[$];
   int       cyc = 0;
   bit       m_ready;
   int       m_len, m_out, m_res, m_req, m_fill, m_wcnt;
   int       m_frames = 0;
   logic [2:0] m_err;
   bit       last_wr;

   function automatic logic [7:0] grey(input logic [15:0] p);
      int r8, g8, b8;
      r8 = int'(p[15:11]) * 8;
      g8 = int'(p[10:5]) * 4;
      b8 = int'(p[4:0]) * 8;
`ifdef PXCONV_LUMA_WEIGHTS_EN
      return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
`else
      return 8'((r8 + g8 + b8) / 3);
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_ready = 1'b0;
      m_len   = PRIME;
      m_out   = 0;
      m_res   = 0;
      m_req   = 0;
      m_fill  = 0;
      m_wcnt  = 0;
      m_err   = '0;
   endtask

   // advance one clock with the current inputs, update the model, compare
   task automatic tick();
      bit          acc_rd, acc_beat, acc_ack, wr;
      wr_t         w;
      logic [63:0] d;
      acc_rd   = rd_start && m_ready;
      acc_beat = valid && (m_out > 0);
      acc_ack  = ack && (m_res > 0);
      if (valid && !acc_beat)  m_err[0] = 1'b1;
      if (ack && !acc_ack)     m_err[1] = 1'b1;
      if (rd_start && !m_ready) m_err[2] = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (acc_beat) begin
         d = '0;
         for (int k = 0; k < PX; k++) d[32*k +: 32] = {24'd0, grey(data[16*k +: 16])};
         w.due  = cyc + 1;
         w.d    = d;
         w.addr = m_wcnt % WND;
         w.last = (m_wcnt == FRAME - 1);
         m_wcnt = w.last ? 0 : m_wcnt + 1;
         q.push_back(w);
      end
      m_out = m_out + (acc_rd ? m_len : 0) - (acc_beat ? 1 : 0);
      m_res = m_res + (acc_rd ? m_len : 0) - (acc_ack ? 1 : 0);
      if (acc_rd) begin
         m_req = m_req + m_len;
         if (m_req >= FRAME) m_req = m_req - FRAME;
      end
      m_len   = (m_req < WND) ? PRIME : STEADY;
      m_ready = ((WND - m_res) >= m_len);
      wr      = (q.size() > 0) && (q[0].due == cyc);
      last_wr = 1'b0;
      if (wr) begin
         w       = q.pop_front();
         last_wr = w.last;
         m_fill++;
      end
      if (acc_ack) m_fill--;
      chk("wr_en", 64'(wr_en), wr ? 64'((1 << PX) - 1) : 64'd0);
      if (wr) begin
         chk("data", 64'(bram_data), w.d);
         chk("addr", 64'(bram_addr), 64'(w.addr));
      end
      chk("frame_done", 64'(fdone), 64'(last_wr));
      if (last_wr) m_frames++;
      chk("ready", 64'(ready), 64'(m_ready));
      chk("len", 64'(len), 64'(m_len));
      chk("wnd", 64'(wnd), 64'(m_fill >= WND));
      chk("err", 64'(err), 64'(m_err));
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      valid    = 1'b0;
      rd_start = 1'b0;
      ack      = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_len", 64'(len), 64'(PRIME));
      chk("rst_we", 64'(bram_we), 64'((1 << (4 * PX)) - 1));
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_data", 64'(bram_data), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_wnd", 64'(wnd), 64'd0);
      chk("rst_fdone", 64'(fdone), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic prime(output int bursts);
      bursts = 0;
      for (int i = 0; i < 60; i++) begin
         rd_start = ready;
         if (ready) bursts++;
         tick();
      end
      rd_start = 1'b0;
   endtask

   int bursts;
   int dut_fd;
   int frames0;

   initial begin
      // priming: rd_start whenever ready, no acks
      do_reset();
      prime(bursts);
      chk("prime_bursts", 64'(bursts), 64'(WND / PRIME));
      chk("prime_ready_low", 64'(ready), 64'd0);
      chk("prime_err", 64'(err), 64'd0);

      // directed grey values, two clocks after the beat
      data = {16'($urandom), 16'hFFFF};
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
`ifdef PXCONV_LUMA_WEIGHTS_EN
      chk("grey_ffff", 64'(bram_data[7:0]), 64'hFA);
`else
      chk("grey_ffff", 64'(bram_data[7:0]), 64'hF9);
`endif
      data = {16'($urandom), 16'hF800};
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
`ifdef PXCONV_LUMA_WEIGHTS_EN
      chk("grey_f800", 64'(bram_data[7:0]), 64'h4A);
`else
      chk("grey_f800", 64'(bram_data[7:0]), 64'h52);
`endif

      // fill the rest of the window with random beats
      for (int i = 0; i < 2000 && m_wcnt < WND; i++) begin
         data  = $urandom;
         valid = ($urandom_range(0, 3) != 0);
         tick();
      end
      valid = 1'b0;
      tick();
      tick();
      chk("wnd_full", 64'(wnd), 64'd1);
      chk("fill_last_addr", 64'(bram_addr), 64'(WND - 1));

      // credit release: one ack is not enough, a steady burst worth is
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("one_ack_ready", 64'(ready), 64'd0);
      ack = 1'b1;
      for (int i = 0; i < STEADY - 1; i++) tick();
      ack = 1'b0;
      chk("acks_ready", 64'(ready), 64'd1);
      chk("steady_len", 64'(len), 64'(STEADY));

      // next burst wraps the window address
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      data  = $urandom;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      chk("wrap_wr_en", 64'(wr_en), 64'((1 << PX) - 1));
      chk("wrap_addr", 64'(bram_addr), 64'd0);

      // random streaming through the end of the frame and a few beats past it
      dut_fd  = 0;
      frames0 = m_frames;
      for (int i = 0; i < 20000 && !((m_frames > frames0) && (m_wcnt >= 4)); i++) begin
         rd_start = ready && ($urandom_range(0, 3) != 0);
         valid    = (m_out > 0) && ($urandom_range(0, 3) != 0);
         data     = $urandom;
         ack      = (m_fill > 0) && (m_res > 0) && ($urandom_range(0, 1) == 1);
         tick();
         if (fdone) dut_fd++;
      end
      chk("frame_done_count", 64'(dut_fd), 64'd1);

      // keep a burst in flight, then reset under it
      for (int i = 0; i < 40 && m_out == 0; i++) begin
         rd_start = ready;
         valid    = 1'b0;
         ack      = (m_fill > 0) && (m_res > 0);
         tick();
      end
      rd_start = 1'b0;
      ack      = 1'b0;
      do_reset();

      // stale beat after reset, then ack with nothing reserved
      data  = $urandom;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("err_unsolicited", 64'(err), 64'b001);
      tick();
      chk("unsolicited_no_write", 64'(wr_en), 64'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("err_ack_underflow", 64'(err), 64'b011);

      // exhaust credit, then request anyway
      prime(bursts);
      chk("reprime_bursts", 64'(bursts), 64'(WND / PRIME));
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("err_rd_not_ready", 64'(err), 64'b111);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
